// File: rtl/lut_sweep_scanner.sv
`default_nettype none
// ============================================================================
// Module   : lut_sweep_scanner
// Purpose  : Sequencer and capture stage wrapped around a combinational
//            lookup circuit. A start request sweeps the lookup address
//            through every code, one per clock. Each returned word is
//            streamed out with its address, and two summaries are built:
//            a rotate-XOR signature and the maximum word with its address.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W     : lookup address width; sweep covers 0 .. 2**ADDR_W-1
//   DATA_W     : lookup data width (must be >= 2)
// Ports
//   clk        : rising-edge clock
//   resetn     : asynchronous active-low reset
//   start      : sweep request (ignored while sweeping)
//   abort      : synchronous abort, priority over start
//   a          : registered address to the lookup circuit
//   q          : lookup result, combinational function of a
//   busy       : high while sweeping
//   done       : one-cycle pulse after a completed sweep
//   word_valid : word_addr/word_data hold a freshly captured sample
//   word_addr  : address of the captured sample
//   word_data  : captured lookup word
//   sig        : rotate-left-1 / XOR signature of the captured words
//   max_val    : largest captured word (unsigned)
//   max_addr   : address of max_val (lowest address on ties)
// ============================================================================
module lut_sweep_scanner #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] q,
  output logic              busy,
  output logic              done,
  output logic              word_valid,
  output logic [ADDR_W-1:0] word_addr,
  output logic [DATA_W-1:0] word_data,
  output logic [DATA_W-1:0] sig,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] max_addr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] C_ADDR_LAST = '1;

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] a_q,        a_d;
  logic              wvalid_q,   wvalid_d;
  logic [ADDR_W-1:0] waddr_q,    waddr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [DATA_W-1:0] sig_q,      sig_d;
  logic [DATA_W-1:0] maxval_q,   maxval_d;
  logic [ADDR_W-1:0] maxaddr_q,  maxaddr_d;

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    wvalid_d  = 1'b0;       // strobe only follows a sample edge
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    sig_d     = sig_q;
    maxval_d  = maxval_q;
    maxaddr_d = maxaddr_q;

    if (abort) begin
      // Abort freezes address and summaries; only the control path returns
      // to idle, so a partial result stays observable.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d   = ST_SWEEP;
            a_d       = '0;
            sig_d     = '0;
            maxval_d  = '0;
            maxaddr_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_SWEEP: begin
          wvalid_d = 1'b1;
          waddr_d  = a_q;
          wdata_d  = q;
          sig_d    = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ q;

          // The first sample always seeds the maximum, so a table of all
          // zeros still reports address 0. Strict compare keeps the lowest
          // address on ties.
          if ((a_q == '0) || (q > maxval_q)) begin
            maxval_d  = q;
            maxaddr_d = a_q;
          end

          if (a_q == C_ADDR_LAST) begin
            state_d = ST_DONE;
          end else begin
            a_d = a_q + 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      wvalid_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      sig_q     <= '0;
      maxval_q  <= '0;
      maxaddr_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      wvalid_q  <= wvalid_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      sig_q     <= sig_d;
      maxval_q  <= maxval_d;
      maxaddr_q <= maxaddr_d;
    end
  end

  // busy/done decode straight from the state register, so they are glitch
  // free and clear immediately on reset.
  assign busy       = (state_q == ST_SWEEP);
  assign done       = (state_q == ST_DONE);
  assign a          = a_q;
  assign word_valid = wvalid_q;
  assign word_addr  = waddr_q;
  assign word_data  = wdata_q;
  assign sig        = sig_q;
  assign max_val    = maxval_q;
  assign max_addr   = maxaddr_q;

endmodule
`default_nettype wire
